branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised, pipelined branch resolution unit for the RV32/RV64 integer core. It accepts one control-flow candidate per cycle from decode/issue and evaluates BRANCH (all six funct3 conditions), JAL and JALR. It produces taken, target and link values, compares them against the fetch-stage prediction, and raises a mispredict that redirects fetch and kills the younger in-flight entry. It sits between the register-read stage and the fetch redirect logic and supersedes the purely combinational comparator.

## Interface
- `XLEN`, 32, operand/PC width (32 or 64)
- `CNT_W`, 32, performance counter width (used only with `BRU_PERF_CNT_EN`)

Ports:
- `clk_in` in 1: single clock, rising edge
- `rst_in` in 1: reset, synchronous, active-high
- `valid_in` in 1: candidate valid
- `ready_out` out 1: unit can accept this cycle
- `pc_in` in XLEN: PC of instruction
- `rs1_in`, `rs2_in` in XLEN: source operands
- `imm_in` in XLEN: sign-extended immediate
- `opcode_6_to_2_in` in 5: instr[6:2]
- `funct3_in` in 3: instr[14:12]
- `pred_taken_in` in 1: fetch prediction, taken
- `pred_target_in` in XLEN: fetch predicted target
- `flush_in` in 1: external pipeline flush
- `valid_out` out 1: result valid
- `ready_in` in 1: consumer accepts result
- `branch_taken_out` out 1: resolved taken
- `target_out` out XLEN: resolved next PC
- `link_out` out XLEN: pc+4 (rd value for JAL/JALR)
- `mispredict_out` out 1: prediction wrong, redirect to `target_out`
- `illegal_out` out 1: BRANCH with funct3 010/011
- `branch_cnt_out`, `mispred_cnt_out` out CNT_W: only with `BRU_PERF_CNT_EN`

## Operation
- Opcodes: 11000 BRANCH, 11011 JAL, 11001 JALR. Any other opcode is passed through with taken=0, target=pc+4.
- BRANCH funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned). 010/011 give taken=0, target=pc+4 and `illegal_out`=1.
- Targets: BRANCH/JAL pc+imm; JALR (rs1+imm) with bit 0 cleared; not-taken pc+4. All sums are modulo 2^XLEN and wrap silently.
- Mispredict = (taken != pred_taken_in) | (taken & target != pred_target_in).
- Stage S1 registers the compare result, target, link and prediction. Stage S2 registers the mispredict evaluation and drives the outputs.
- Handshake: an input is accepted when valid_in & ready_out. The result retires when valid_out & ready_in. The pipeline advances when S2 is empty or retiring. ready_out = !S1_valid | advance.
- Mispredict kill: when a mispredicting result retires, S1 is invalidated and a same-cycle input is dropped (ready_out forced 0 that cycle).
- flush_in clears S1 and S2 valids at the next edge and blocks same-cycle acceptance. Flush takes priority over every other event.

## Timing
- Latency: 2 cycles from acceptance to valid_out with no back-pressure. Throughput is 1 per cycle.
- Under back-pressure (valid_out & !ready_in), all outputs hold stable until retirement.
- Reset: S1/S2 valids 0, valid_out 0, branch_taken_out 0, mispredict_out 0, illegal_out 0, target_out 0, link_out 0, counters 0. ready_out is 0 during the reset cycle and 1 after.
- Reset mid-operation discards all in-flight entries. No partial retirement occurs.
- Simultaneous flush and retirement: the retirement is still seen by the consumer in that cycle, and state clears afterwards.

## Configuration
- `BRU_PERF_CNT_EN` defined:
  - `branch_cnt_out` increments on each retired BRANCH/JAL/JALR.
  - `mispred_cnt_out` increments on each retired mispredict.
  - Both saturate at all-ones and clear only on rst_in.
- `BRU_PERF_CNT_EN` undefined: counter ports and logic are absent.

## Structure
- Package `bru_pkg` holds:
  - opcode constants (OP_BRANCH, OP_JAL, OP_JALR)
  - funct3 constants (F3_BEQ…F3_BGEU)
  - the S1 payload struct typedef
- Sub-module `branch_cmp`: combinational XLEN-parametrised comparator (eq, lt, ltu → taken from funct3), instantiated in S1.

## Test plan
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 → two cycles later taken=1, target=0x120, mispredict=0.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken=1. Same operands as BLTU → taken=0, target=pc+4, and mispredict=1 if pred_taken=1.
- JALR rs1=0x1001, imm=2, pc=0x40 → target=0x1002, link=0x44, taken=1. With pc=0xFFFFFFFC, link wraps to 0x0.
- Back-pressure: hold ready_in=0 for 3 cycles with 3 valid inputs → outputs stable, ready_out drops when both stages are full, and no entry is lost or duplicated.
- Mispredict kill: mispredicting branch followed by a valid younger entry → younger entry never appears on valid_out. flush_in with both stages full → valid_out=0 next cycle.
- With `BRU_PERF_CNT_EN` and CNT_W=4: 20 retired mispredicts → mispred_cnt_out=0xF (saturated). funct3=010 → illegal_out=1, taken=0.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared constants and S1 payload type for the branch resolve unit.
// Opcode/funct3 encodings follow the RV32I/RV64I base ISA.
package bru_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic taken;
    logic pred_taken;
    logic illegal;
    logic is_cf;
  } s1_payload_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Reserved funct3 codes (010/011) resolve to not-taken.
module branch_cmp
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_funct3,
  output logic            o_taken
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  // select the condition named by funct3
  always_comb begin
    o_taken = 1'b0;
    unique case (i_funct3)
      F3_BEQ:  o_taken = w_eq;
      F3_BNE:  o_taken = ~w_eq;
      F3_BLT:  o_taken = w_lt;
      F3_BGE:  o_taken = ~w_lt;
      F3_BLTU: o_taken = w_ltu;
      F3_BGEU: o_taken = ~w_ltu;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 resolves, S2 evaluates mispredict.
// Optional perf counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  input  logic            pred_taken_in,
  input  logic [XLEN-1:0] pred_target_in,
  input  logic            flush_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] target_out,
  output logic [XLEN-1:0] link_out,
  output logic            mispredict_out,
  output logic            illegal_out
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] branch_cnt_out,
  output logic [CNT_W-1:0] mispred_cnt_out
`endif
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_cmp_taken;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_rs1_imm;
  logic [XLEN-1:0] w_target;
  s1_payload_t     w_pl;
  logic            w_retire;
  logic            w_kill;
  logic            w_adv;
  logic            w_s1_open;
  logic            w_accept;
  logic            w_mis;

  logic            r_s1_valid;
  s1_payload_t     r_s1_pl;
  logic [XLEN-1:0] r_s1_target;
  logic [XLEN-1:0] r_s1_link;
  logic [XLEN-1:0] r_s1_pred_target;

  logic            r_s2_valid;
  logic            r_s2_taken;
  logic [XLEN-1:0] r_s2_target;
  logic [XLEN-1:0] r_s2_link;
  logic            r_s2_mis;
  logic            r_s2_ill;
  logic            r_s2_cf;

  assign w_is_br   = (opcode_6_to_2_in == OP_BRANCH);
  assign w_is_jal  = (opcode_6_to_2_in == OP_JAL);
  assign w_is_jalr = (opcode_6_to_2_in == OP_JALR);
  assign w_pc4     = pc_in + FOUR;
  assign w_pc_imm  = pc_in + imm_in;
  assign w_rs1_imm = rs1_in + imm_in;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_rs1    (rs1_in),
    .i_rs2    (rs2_in),
    .i_funct3 (funct3_in),
    .o_taken  (w_cmp_taken)
  );

  // decode the candidate into taken/target/flags
  always_comb begin
    w_pl            = '0;
    w_pl.pred_taken = pred_taken_in;
    w_target        = w_pc4;
    unique case (1'b1)
      w_is_br: begin
        w_pl.is_cf   = 1'b1;
        w_pl.illegal = (funct3_in[2:1] == 2'b01);
        w_pl.taken   = w_cmp_taken;
        if (w_cmp_taken) w_target = w_pc_imm;
      end
      w_is_jal: begin
        w_pl.is_cf = 1'b1;
        w_pl.taken = 1'b1;
        w_target   = w_pc_imm;
      end
      w_is_jalr: begin
        w_pl.is_cf = 1'b1;
        w_pl.taken = 1'b1;
        w_target   = {w_rs1_imm[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_retire  = r_s2_valid & ready_in;
  assign w_kill    = w_retire & r_s2_mis;
  assign w_adv     = ~r_s2_valid | ready_in;
  assign w_s1_open = w_adv | ~r_s1_valid;
  assign ready_out = ~rst_in & ~flush_in & ~w_kill & w_s1_open;
  assign w_accept  = valid_in & ready_out;

  assign w_mis = (r_s1_pl.taken != r_s1_pl.pred_taken)
               | (r_s1_pl.taken & (r_s1_target != r_s1_pred_target));

  // S1: capture resolved candidate; kill or flush drops it
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid       <= 1'b0;
      r_s1_pl          <= '0;
      r_s1_target      <= '0;
      r_s1_link        <= '0;
      r_s1_pred_target <= '0;
    end else if (flush_in | w_kill) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_open) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pl          <= w_pl;
        r_s1_target      <= w_target;
        r_s1_link        <= w_pc4;
        r_s1_pred_target <= pred_target_in;
      end
    end
  end

  // S2: register mispredict and hold outputs under back-pressure
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s2_valid  <= 1'b0;
      r_s2_taken  <= 1'b0;
      r_s2_target <= '0;
      r_s2_link   <= '0;
      r_s2_mis    <= 1'b0;
      r_s2_ill    <= 1'b0;
      r_s2_cf     <= 1'b0;
    end else if (flush_in) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid & ~w_kill;
      if (r_s1_valid & ~w_kill) begin
        r_s2_taken  <= r_s1_pl.taken;
        r_s2_target <= r_s1_target;
        r_s2_link   <= r_s1_link;
        r_s2_mis    <= w_mis;
        r_s2_ill    <= r_s1_pl.illegal;
        r_s2_cf     <= r_s1_pl.is_cf;
      end
    end
  end

  assign valid_out        = r_s2_valid;
  assign branch_taken_out = r_s2_taken;
  assign target_out       = r_s2_target;
  assign link_out         = r_s2_link;
  assign mispredict_out   = r_s2_mis;
  assign illegal_out      = r_s2_ill;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  // saturating counts of retired control flow and mispredicts
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_retire) begin
      if (r_s2_cf & ~&r_br_cnt)
        r_br_cnt <= r_br_cnt + 1'b1;
      if (r_s2_mis & ~&r_mis_cnt)
        r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign branch_cnt_out  = r_br_cnt;
  assign mispred_cnt_out = r_mis_cnt;
`else
  logic             w_unused_cf;
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cf  = r_s2_cf;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit against a
// transaction-level queue model of the two-entry pipeline.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  logic        clk = 0;
  logic        rst = 1;
  logic        vin = 0;
  logic        rdy_o;
  logic [31:0] pc = 0, rs1 = 0, rs2 = 0, imm = 0;
  logic [4:0]  op = 0;
  logic [2:0]  f3 = 0;
  logic        pt = 0;
  logic [31:0] ptg = 0;
  logic        fl = 0;
  logic        vout;
  logic        rdy_i = 0;
  logic        tk;
  logic [31:0] tgt, lnk;
  logic        mis, ill;
`ifdef BRU_PERF_CNT_EN
  logic [3:0]  bcnt, mcnt;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .valid_in         (vin),
    .ready_out        (rdy_o),
    .pc_in            (pc),
    .rs1_in           (rs1),
    .rs2_in           (rs2),
    .imm_in           (imm),
    .opcode_6_to_2_in (op),
    .funct3_in        (f3),
    .pred_taken_in    (pt),
    .pred_target_in   (ptg),
    .flush_in         (fl),
    .valid_out        (vout),
    .ready_in         (rdy_i),
    .branch_taken_out (tk),
    .target_out       (tgt),
    .link_out         (lnk),
    .mispredict_out   (mis),
    .illegal_out      (ill)
`ifdef BRU_PERF_CNT_EN
    ,
    .branch_cnt_out   (bcnt),
    .mispred_cnt_out  (mcnt)
`endif
  );

  typedef struct {
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] link;
    logic        mis;
    logic        ill;
    logic        cf;
    int          stamp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mbr = 0;
  int   mmis = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Architectural result straight from the ISA rules.
  function automatic exp_t resolve(
    logic [31:0] p, logic [31:0] a, logic [31:0] b,
    logic [31:0] im, logic [4:0] o, logic [2:0] f,
    logic prt, logic [31:0] prg);
    exp_t e;
    e.taken = 0; e.link = p + 4; e.tgt = p + 4;
    e.ill = 0; e.cf = 0; e.stamp = 0;
    if (o == 5'b11000) begin
      e.cf = 1;
      case (f)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = ($signed(a) < $signed(b));
        3'd5: e.taken = ($signed(a) >= $signed(b));
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: e.ill = 1;
      endcase
      if (e.taken) e.tgt = p + im;
    end else if (o == 5'b11011) begin
      e.cf = 1; e.taken = 1; e.tgt = p + im;
    end else if (o == 5'b11001) begin
      e.cf = 1; e.taken = 1; e.tgt = (a + im) & ~32'd1;
    end
    e.mis = (e.taken != prt) || (e.taken && e.tgt != prg);
    return e;
  endfunction

  task automatic step(
    bit v, logic [31:0] p, logic [31:0] a, logic [31:0] b,
    logic [31:0] im, logic [4:0] o, logic [2:0] f,
    bit prt, logic [31:0] prg, bit r, bit fx, bit rx);
    bit   ev, er, acc, ret, kill;
    exp_t e;
    @(negedge clk);
    vin = v; pc = p; rs1 = a; rs2 = b; imm = im;
    op = o; f3 = f; pt = prt; ptg = prg;
    rdy_i = r; fl = fx; rst = rx;
    #1;
    ev = (q.size() > 0) && (q[0].stamp < cyc);
    er = !rx && !fx && !(ev && r && q[0].mis)
         && (q.size() < 2 || r);
    chk("valid_out", 32'(vout), 32'(ev));
    chk("ready_out", 32'(rdy_o), 32'(er));
    if (ev) begin
      chk("taken", 32'(tk), 32'(q[0].taken));
      chk("target", tgt, q[0].tgt);
      chk("link", lnk, q[0].link);
      chk("mispredict", 32'(mis), 32'(q[0].mis));
      chk("illegal", 32'(ill), 32'(q[0].ill));
    end
`ifdef BRU_PERF_CNT_EN
    chk("branch_cnt", 32'(bcnt), 32'(mbr));
    chk("mispred_cnt", 32'(mcnt), 32'(mmis));
`endif
    acc  = v && er;
    ret  = ev && r;
    kill = ret && q[0].mis;
    e = resolve(p, a, b, im, o, f, prt, prg);
    @(posedge clk);
    cyc++;
    if (rx) begin
      q.delete(); mbr = 0; mmis = 0;
    end else begin
      if (ret) begin
        if (q[0].cf && mbr < 15) mbr++;
        if (q[0].mis && mmis < 15) mmis++;
      end
      if (fx) q.delete();
      else begin
        if (ret) void'(q.pop_front());
        if (kill) q.delete();
        if (acc) begin
          e.stamp = cyc;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(bit r);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r, 0, 0);
  endtask

  initial begin
    exp_t        g;
    logic [31:0] rp, ra, rb, ri, rg;
    logic [4:0]  ro;
    logic [2:0]  rf;
    bit          rt, rv, rr, rfl, rrs;
    int          sel;

    @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, OP_JAL, 0, 0, 0, 1, 0, 1);
    chk("rst_taken", 32'(tk), 0);
    chk("rst_target", tgt, 0);
    chk("rst_link", lnk, 0);
    chk("rst_mis", 32'(mis), 0);
    chk("rst_ill", 32'(ill), 0);

    // BEQ correctly predicted taken
    step(1, 32'h100, 5, 5, 32'h20, OP_BRANCH, F3_BEQ,
         1, 32'h120, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // BLT signed vs BLTU unsigned on the same operands
    step(1, 32'h200, 32'hFFFFFFFF, 1, 32'h10, OP_BRANCH,
         F3_BLT, 1, 32'h210, 1, 0, 0);
    step(1, 32'h300, 32'hFFFFFFFF, 1, 32'h10, OP_BRANCH,
         F3_BLTU, 1, 32'h310, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // JALR bit-0 clear and link wrap
    step(1, 32'h40, 32'h1001, 0, 2, OP_JALR, 0,
         1, 32'h1002, 1, 0, 0);
    step(1, 32'hFFFFFFFC, 32'h1001, 0, 2, OP_JALR, 0,
         1, 32'h1002, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // back-pressure with three well-predicted JALs
    for (int i = 0; i < 3; i++)
      step(1, 32'h1000 + 32'(i * 4), 0, 0, 32'h80, OP_JAL,
           0, 1, 32'h1080 + 32'(i * 4), 0, 0, 0);
    for (int i = 0; i < 4; i++) idle(1);

    // mispredicted BNE must kill the younger entry
    step(1, 32'h500, 1, 2, 32'h40, OP_BRANCH, F3_BNE,
         0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'h600, 0, 0, 8, OP_JAL, 0,
           1, 32'h608, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // flush with both stages full
    step(1, 32'h700, 0, 0, 8, OP_JAL, 0, 1, 32'h708, 0, 0, 0);
    step(1, 32'h704, 0, 0, 8, OP_JAL, 0, 1, 32'h70C, 0, 0, 0);
    step(1, 32'h708, 0, 0, 8, OP_JAL, 0, 1, 32'h710, 1, 1, 0);
    idle(1); idle(1);

    // reserved funct3 flagged illegal
    step(1, 32'h800, 3, 3, 32'h10, OP_BRANCH, 3'b010,
         0, 0, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // twenty retired mispredicts (saturates a 4-bit counter)
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h900, 0, 0, 32'h10, OP_JAL, 0,
           0, 0, 1, 0, 0);
      idle(1); idle(1);
    end
    idle(1);

    // randomized traffic with stalls, flushes and resets
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) ro = OP_BRANCH;
      else if (sel < 7) ro = OP_JAL;
      else if (sel < 9) ro = OP_JALR;
      else ro = 5'($urandom);
      rf = 3'($urandom);
      rp = $urandom & ~32'd3;
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom_range(0, 3);
        rb = $urandom_range(0, 3);
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      ri = $urandom;
      rt = 1'($urandom);
      g  = resolve(rp, ra, rb, ri, ro, rf, rt, 0);
      rg = ($urandom_range(0, 1) == 0) ? g.tgt : $urandom;
      rv  = ($urandom_range(0, 9) < 7);
      rr  = ($urandom_range(0, 3) != 0);
      rfl = ($urandom_range(0, 39) == 0);
      rrs = ($urandom_range(0, 199) == 0);
      step(rv, rp, ra, rb, ri, ro, rf, rt, rg, rr, rfl, rrs);
    end
    idle(1); idle(1); idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
